// File: rtl/alu_seq_pkg.sv
// Shared types and the hex display font for the sequential ALU core.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpXor = 3'b100,
    OpShl = 3'b101,
    OpShr = 3'b110,
    OpMul = 3'b111
  } op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StMul  = 1'b1
  } state_e;

  // Active-low segments, bit 0 = a ... bit 6 = g; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HexSeg = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HexSeg[nib];
  endfunction

endpackage

// File: rtl/hex_scan.sv
// Multiplexed 4-digit 7-segment scanner with a free-running refresh counter.
module hex_scan
  import alu_seq_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  logic [REFRESH_BITS-1:0] cnt_q;
  logic [1:0]              idx;
  logic [3:0]              nib;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    idx = cnt_q[REFRESH_BITS-1 -: 2];
    an  = ~(4'b0001 << idx);
    nib = value[{idx, 2'b00} +: 4];
    seg = hex_to_seg(nib);
  end

endmodule

// File: rtl/alu_seq_core.sv
// Clocked ALU with start/busy/done handshake, accumulator mode, shift-add
// multiplier and a built-in hex display scanner.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned REFRESH_BITS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         acc_mode,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] result_hi,
  output logic         carry,
  output logic         zero,
  output logic         ovf,
  output logic [6:0]   seg,
  output logic [3:0]   an
);

  localparam int unsigned SW = $clog2(W);
  localparam logic [SW-1:0] LastCnt = SW'(W - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2*W-1:0]   prod_q, prod_d, prod_nxt;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [W-1:0]     result_q, result_d, result_hi_q, result_hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, done_q, done_d;

  logic [W-1:0]     opa, res;
  logic [W:0]       sum, diff, step;
  logic [SW-1:0]    shamt;
  logic             car, ov;
  op_e              op_sel;

  always_comb begin
    op_sel = op_e'(op);
    opa    = acc_mode ? result_q : a;
    sum    = {1'b0, opa} + {1'b0, b} + {{W{1'b0}}, cin};
    diff   = {1'b0, opa} - {1'b0, b};
    shamt  = b[SW-1:0];
    res    = '0;
    car    = 1'b0;
    ov     = 1'b0;
    unique case (op_sel)
      OpAdd: begin
        res = sum[W-1:0];
        car = sum[W];
        ov  = (opa[W-1] == b[W-1]) && (res[W-1] != opa[W-1]);
      end
      OpSub: begin
        res = diff[W-1:0];
        car = ~diff[W];
        ov  = (opa[W-1] != b[W-1]) && (res[W-1] != opa[W-1]);
      end
      OpAnd:   res = opa & b;
      OpOr:    res = opa | b;
      OpXor:   res = opa ^ b;
      OpShl:   res = opa << shamt;
      OpShr:   res = opa >> shamt;
      default: res = '0;
    endcase
    // One shift-add step: add into the upper half, then shift the whole product right.
    step     = {1'b0, prod_q[2*W-1:W]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt = {step, prod_q[W-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (op_sel == OpMul) begin
            mcand_d  = opa;
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            result_d    = res;
            result_hi_d = '0;
            carry_d     = car;
            zero_d      = (res == '0);
            ovf_d       = ov;
            done_d      = 1'b1;
          end
        end
      end
      StMul: begin
        prod_d   = prod_nxt;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          result_d    = prod_nxt[W-1:0];
          result_hi_d = prod_nxt[2*W-1:W];
          carry_d     = 1'b0;
          zero_d      = (prod_nxt == '0);
          ovf_d       = (prod_nxt[2*W-1:W] != '0);
          done_d      = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == StMul);
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

  logic [15:0] disp_val;
  always_comb begin
    disp_val        = '0;
    disp_val[W-1:0] = result_q;
  end

  hex_scan #(
    .REFRESH_BITS(REFRESH_BITS)
  ) u_hex_scan (
    .clk  (clk),
    .rst_n(rst_n),
    .value(disp_val),
    .seg  (seg),
    .an   (an)
  );

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core: directed ops push expectations, a done-monitor checks them.
module tb_alu_seq_core;

  localparam int W  = 8;
  localparam int RB = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, cin, acc_mode;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry, zero, ovf;
  logic [W-1:0] result, result_hi;
  logic [6:0]   seg;
  logic [3:0]   an;

  alu_seq_core #(
    .W           (W),
    .REFRESH_BITS(RB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .acc_mode (acc_mode),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .result_hi(result_hi),
    .carry    (carry),
    .zero     (zero),
    .ovf      (ovf),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, 32'(result), 32'(e.res));
        check({e.name, "_result_hi"}, 32'(result_hi), 32'(e.hi));
        check({e.name, "_carry"}, 32'(carry), 32'(e.c));
        check({e.name, "_zero"}, 32'(zero), 32'(e.z));
        check({e.name, "_ovf"}, 32'(ovf), 32'(e.v));
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic acc);
    @(posedge clk);
    #1;
    op = o; a = av; b = bv; cin = ci; acc_mode = acc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic ci, input logic acc,
                        input logic [W-1:0] res, input logic [W-1:0] hi, input logic c,
                        input logic z, input logic v, input int lat);
    int got;
    int n;
    sb.push_back('{name, res, hi, c, z, v});
    issue(o, av, bv, ci, acc);
    got = 0;
    n   = 0;
    for (int i = 1; i <= 20 && got == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1;
        n   = i;
      end else if (lat == 1 && busy !== 1'b0) begin
        check({name, "_busy_low"}, 32'(busy), 32'd0);
      end
    end
    check({name, "_latency"}, n, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [6:0] exp_seg [4];

  initial begin
    int got;
    int dhi;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0; cin = 1'b0; acc_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'({result_hi, result}), 0);
    check("rst_flags", 32'({carry, zero, ovf}), 0);
    check("rst_an", 32'(an), 32'h0000000E);
    rst_n = 1'b1;

    // Single-cycle arithmetic
    run_op("add_f0_20", 3'b000, 8'hF0, 8'h20, 1'b1, 1'b0, 8'h11, 8'h00, 1'b1, 1'b0, 1'b0, 1);
    run_op("sub_80_01", 3'b001, 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b0, 1'b1, 1);
    run_op("sub_05_05", 3'b001, 8'h05, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1);

    // MUL FF*FF with an ignored start mid-flight
    sb.push_back('{"mul_ff_ff", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1});
    issue(3'b111, 8'hFF, 8'hFF, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i <= 8) begin
        check("mul_busy", 32'(busy), 1);
        check("mul_hold_result", 32'(result), 0);
        check("mul_no_early_done", 32'(done), 0);
      end else begin
        check("mul_done_cycle9", 32'(done), 1);
        check("mul_busy_drop", 32'(busy), 0);
      end
      if (i == 3) begin
        op = 3'b000; a = 8'h01; b = 8'h01; acc_mode = 1'b0; start = 1'b1;
      end
      if (i == 4) start = 1'b0;
    end
    repeat (3) @(negedge clk);

    // Accumulator chaining
    run_op("add_5_3", 3'b000, 8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run_op("acc_add3", 3'b000, 8'hAA, 8'h03, 1'b0, 1'b1, 8'h0B, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    run_op("acc_shl2", 3'b101, 8'h00, 8'h0A, 1'b0, 1'b1, 8'h2C, 8'h00, 1'b0, 1'b0, 1'b0, 1);

    // MUL aborted by reset on its 4th iteration edge
    issue(3'b111, 8'h0F, 8'h11, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) rst_n = 1'b0;
    end
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_result", 32'(result), 0);
    check("abort_result_hi", 32'(result_hi), 0);
    check("abort_done", 32'(done), 0);
    rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) got++;
    end
    check("abort_no_done", got, 0);
    run_op("add_1_2", 3'b000, 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1);

    // Display scan of 0x3C
    run_op("add_3c", 3'b000, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, 1);
    exp_seg[0] = 7'b1000110;
    exp_seg[1] = 7'b0110000;
    exp_seg[2] = 7'b1000000;
    exp_seg[3] = 7'b1000000;
    got = 0;
    for (int i = 0; i < 64 && got == 0; i++) begin
      @(negedge clk);
      if (an === 4'b1110) got = 1;
    end
    dhi = 0;
    for (int i = 0; i < 64 && dhi == 0; i++) begin
      @(negedge clk);
      if (an === 4'b1101) dhi = 1;
    end
    check("scan_sync", got + dhi, 2);
    for (int k = 0; k < 20; k++) begin
      int d;
      logic [3:0] ea;
      if (k > 0) @(negedge clk);
      d  = (1 + k / 4) % 4;
      ea = ~(4'b0001 << d);
      check("scan_an", 32'(an), 32'(ea));
      check("scan_seg", 32'(seg), 32'(exp_seg[d]));
    end

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
